// File: rtl/pe_accumulator_if.sv
// Handshake bundle between the PE multiplier/control side and the accumulator.
// The master drives the run control and products; the slave returns the result.
interface pe_accumulator_if #(
    parameter int BITWIDTH  = 8,
    parameter int ACC_WIDTH = 24
);
    logic                    start;
    logic [ACC_WIDTH-1:0]    bias;
    logic                    prod_valid;
    logic [2*BITWIDTH-1:0]   prod;
    logic                    busy;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_WIDTH-1:0]    acc_out;
    logic                    overflow;

    modport master (
        output start, bias, prod_valid, prod, out_ready,
        input  busy, out_valid, acc_out, overflow
    );

    modport slave (
        input  start, bias, prod_valid, prod, out_ready,
        output busy, out_valid, acc_out, overflow
    );
endinterface

// File: rtl/pe_accumulator.sv
// Saturating accumulator for NUM_TERMS unsigned products on top of a start-time bias,
// with a registered valid/ready result port.
module pe_accumulator #(
    parameter int BITWIDTH  = 8,
    parameter int ACC_WIDTH = 24,
    parameter int NUM_TERMS = 9
) (
    input  logic              fast_clk,
    input  logic              rst,
    pe_accumulator_if.slave   pe
);
    localparam int CNT_W = $clog2(NUM_TERMS + 1);
    localparam int PAD_W = ACC_WIDTH + 1 - 2*BITWIDTH;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t               state, state_nxt;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     count;
    logic                 overflow_q;
    logic                 busy_q;
    logic                 out_valid_q;
    logic [ACC_WIDTH:0]   sum;
    logic                 last_term;
    logic                 handshake;
    logic                 take_start;

    // One spare bit catches the carry that triggers saturation.
    assign sum        = {1'b0, acc} + {{PAD_W{1'b0}}, pe.prod};
    assign last_term  = (count == CNT_W'(NUM_TERMS - 1));
    assign handshake  = (state == HOLD) && pe.out_ready;
    assign take_start = pe.start && ((state == IDLE) || handshake);

    always_ff @(posedge fast_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pe.start) state_nxt = ACC;
            ACC:     if (pe.prod_valid && last_term) state_nxt = HOLD;
            HOLD:    if (pe.out_ready) state_nxt = pe.start ? ACC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            acc         <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            busy_q      <= (state_nxt != IDLE);
            out_valid_q <= (state_nxt == HOLD);
            if (take_start) begin
                acc        <= pe.bias;
                count      <= '0;
                overflow_q <= 1'b0;
            end else if ((state == ACC) && pe.prod_valid) begin
                count <= count + CNT_W'(1);
                if (sum[ACC_WIDTH]) begin
                    acc        <= '1;
                    overflow_q <= 1'b1;
                end else begin
                    acc <= sum[ACC_WIDTH-1:0];
                end
            end
        end
    end

    assign pe.busy      = busy_q;
    assign pe.out_valid = out_valid_q;
    assign pe.acc_out   = acc;
    assign pe.overflow  = overflow_q;
endmodule

// File: doc/pe_accumulator.md
# pe_accumulator

Downstream stage of the PE shift-add multiplier. Sums a fixed number of unsigned products (one per multiplier result, qualified by `prod_valid`) on top of a start-time bias. Presents the saturated sum with a valid/ready handshake to the PE output path. One dot-product term group, e.g. a 3x3 convolution window, is processed per run.

## Interface
- `BITWIDTH`, 8, operand width of the upstream multiplier; products are `2*BITWIDTH` bits.
- `ACC_WIDTH`, 24, accumulator and result width; must be >= `2*BITWIDTH`.
- `NUM_TERMS`, 9, products per run; must be >= 1.
- `fast_clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: begin a run; honoured only in IDLE, or in HOLD on the output handshake cycle.
- `bias` input ACC_WIDTH: unsigned initial accumulator value, sampled with an honoured `start`.
- `prod_valid` input 1: `prod` carries a finished product this cycle.
- `prod` input 2*BITWIDTH: unsigned product from the multiplier.
- `busy` output 1: high in ACC and HOLD.
- `out_valid` output 1: `acc_out` holds a final result (HOLD).
- `out_ready` input 1: consumer accepts the result.
- `acc_out` output ACC_WIDTH: accumulated result.
- `overflow` output 1: at least one saturation occurred in the current or last run.

## Operation
- States: IDLE, ACC, HOLD.
- Reset: state IDLE; accumulator, term counter, `acc_out`, `busy`, `out_valid` and `overflow` all 0.
- IDLE + `start`: acc <= `bias`, count <= 0, overflow <= 0, go to ACC. `prod_valid` in IDLE is ignored.
- ACC + `prod_valid`: acc <= sat(acc + `prod`), where `prod` is zero-extended to ACC_WIDTH+1 bits. count <= count+1.
  - If the sum exceeds 2^ACC_WIDTH-1, acc <= all ones and overflow <= 1 (sticky for the run).
  - If count == NUM_TERMS-1 on an accepted product, go to HOLD.
  - Cycles with `prod_valid` low leave acc and count unchanged. There is no timeout.
  - `start` in ACC is ignored.
- HOLD: `acc_out` = acc and is stable. `out_valid` = 1.
  - `prod_valid` and `start` are ignored, except `start` on the handshake cycle.
  - `out_valid` && `out_ready`: go to IDLE. If `start` is also high that cycle, go directly to ACC with the new `bias` (overflow cleared).
- `acc_out` is driven from the accumulator register in every state. It is only meaningful while `out_valid` is high.
- The counter width is the ceiling log2 of NUM_TERMS+1. The counter never wraps within a run.
- `rst` has priority over every other input in every state. Reset mid-run discards the partial sum.

## Timing
- `start` honoured at edge t: `busy` = 1 from t+1. The first product can be accepted at edge t+1.
- Latency: the final product accepted at edge t_n gives `out_valid` = 1 and the final `acc_out` from t_n+1. No combinational path exists from `prod` to `acc_out`.
- Products can be accepted on every cycle; gaps in `prod_valid` are allowed.
- Minimum run length is NUM_TERMS+1 cycles from `start` to `out_valid`.
- Back-to-back runs: handshake plus `start` at edge h gives `busy` staying 1, `out_valid` = 0 from h+1, and the next product accepted at h+1.
- `out_valid` and `busy` are registered outputs. `out_ready` is used only in HOLD. `out_valid` does not depend combinationally on `out_ready`.

## Test plan
- **Full-scale run.** Defaults, bias=0, nine products of 65025 (255*255) on consecutive cycles.
  - Required: `acc_out`=585225 and `out_valid`=1 exactly one cycle after the 9th product; `overflow`=0.
- **Bias and gaps.** bias=100, products 1..9 with `prod_valid` high every other cycle.
  - Required: `acc_out`=145; the unused idle cycles do not change the sum.
- **Saturation.** ACC_WIDTH=17, NUM_TERMS=3, three products of 65025.
  - Required: `acc_out`=131071 and `overflow`=1.
  - Then a new run with products 1,1,1: `acc_out`=3 and `overflow`=0.
- **Backpressure.** `out_ready` held low for 5 cycles in HOLD while `prod_valid` and `start` toggle.
  - Required: `acc_out` stable and `out_valid`=1 throughout; state unchanged.
  - Then `out_ready`=1 with `start`=1 and bias=7: `out_valid`=0 next cycle, `busy`=1, and the new run sums from 7.
- **Reset mid-run.** `rst` asserted for 1 cycle after 4 of 9 products.
  - Required: the next cycle shows `busy`=0, `out_valid`=0, `acc_out`=0, `overflow`=0.
  - A following full run with products all 2 gives `acc_out`=18.
- **Spurious inputs in IDLE.** `prod_valid` pulses and `out_ready` high with no `start`.
  - Required: `busy` and `out_valid` stay 0 and `acc_out` stays 0.
